// File: rtl/link_share_arbiter_if.sv
// link_share_arbiter_if: token bundle between requesters, arbiter and link.
// slave = arbiter side, master = requester/downstream side.
//   I_FTk     requester forward tokens {v,a,c,r,d}, requester k at slice k
//   O_BTk     backward tokens to requesters {n,t,v,c}
//   O_FTk     registered forward token to the downstream link
//   I_BTk     backward token from downstream {n,t,v,c}
//   O_Grant   one-hot owner, O_Busy not idle, O_Timeout forced release
interface link_share_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_FTK = 36
);
  logic [NUM_REQ*WIDTH_FTK-1:0] I_FTk;
  logic [NUM_REQ*4-1:0]         O_BTk;
  logic [WIDTH_FTK-1:0]         O_FTk;
  logic [3:0]                   I_BTk;
  logic [NUM_REQ-1:0]           O_Grant;
  logic                         O_Busy;
  logic                         O_Timeout;

  modport slave (
    input  I_FTk, I_BTk,
    output O_BTk, O_FTk, O_Grant, O_Busy, O_Timeout
  );

  modport master (
    output I_FTk, I_BTk,
    input  O_BTk, O_FTk, O_Grant, O_Busy, O_Timeout
  );
endinterface

// File: rtl/link_share_arbiter.sv
// link_share_arbiter: round-robin owner of one outgoing link channel.
// Ports: clock, reset (sync, active-high), bus (link_share_arbiter_if.slave).
// Optional idle-owner timeout: define ARB_TIMEOUT_EN.
module link_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_FTK  = WIDTH_DATA + 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  link_share_arbiter_if.slave  bus
);
  localparam int W  = WIDTH_FTK;
  localparam int IW = $clog2(NUM_REQ);
  localparam int V  = W - 1;
  localparam int A  = W - 2;
  localparam int R  = W - 4;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      WIDTH_FTK != WIDTH_DATA + 4 ||
      TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_cfg
    $error("link_share_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE, S_FWD, S_WAIT, S_REL
  } state_t;

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     own;
  logic [NUM_REQ-1:0] grant_q;
  logic [W-1:0]      ftk_q;

  logic [W-1:0]       tok [NUM_REQ];
  logic [NUM_REQ-1:0] req_v;
  logic [NUM_REQ-1:0] req_a;
  logic [W-1:0]       own_tok;
  logic               own_v;
  logic               cand_ok;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      idx;
  logic               bt_n;
  logic               bt_t;
  logic               idle;
  logic               xfer;
  logic               fwd_go;
  logic               rel_pend;
  logic               tmo_hit;
  logic [NUM_REQ*4-1:0] btk;

  always_comb begin
    req_v = '0;
    req_a = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      tok[k]   = bus.I_FTk[k*W +: W];
      req_v[k] = tok[k][V];
      req_a[k] = tok[k][A];
    end
  end

  // First requesting channel at or after the pointer, wrapping.
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (!cand_ok && req_v[idx] && req_a[idx]) begin
        cand_ok = 1'b1;
        cand    = idx;
      end
    end
  end

  assign own_tok  = tok[own];
  assign own_v    = own_tok[V];
  assign bt_n     = bus.I_BTk[3];
  assign bt_t     = bus.I_BTk[2];
  assign idle     = (state == S_IDLE);
  assign xfer     = (state == S_FWD) || (state == S_WAIT);
  assign fwd_go   = (state == S_FWD) && !bt_t && !bt_n;
  // The release token already sits on the link; drop it next edge.
  assign rel_pend = ftk_q[V] & ftk_q[R];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       tmo_q;
  assign tmo_hit = fwd_go && !rel_pend && !own_v &&
                   (idle_cnt == 8'(TIMEOUT - 1));
  assign bus.O_Timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.O_Timeout = 1'b0;
`endif

  // Owner sees downstream; everyone else asking gets nacked,
  // except the channel being granted this very cycle.
  always_comb begin
    btk = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!reset) begin
        if (grant_q[k]) begin
          btk[k*4+3] = xfer & bt_n;
          btk[k*4+2] = (xfer & bt_t) | tmo_hit;
          btk[k*4+1] = bus.I_BTk[1];
          btk[k*4+0] = bus.I_BTk[0];
        end else begin
          btk[k*4+3] = req_v[k] &
            ~(idle & cand_ok & (cand == IW'(k)));
        end
      end
    end
  end

  assign bus.O_BTk   = btk;
  assign bus.O_FTk   = ftk_q;
  assign bus.O_Grant = grant_q;
  assign bus.O_Busy  = !idle;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      own     <= '0;
      grant_q <= '0;
      ftk_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (cand_ok) begin
            grant_q <= NUM_REQ'(1) << cand;
            own     <= cand;
            ftk_q   <= tok[cand];
            state   <= S_FWD;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end else begin
            ftk_q[V] <= 1'b0;
          end
        end
        S_FWD: begin
          if (bt_t) begin
            ftk_q[V] <= 1'b0;
            state    <= S_REL;
          end else if (bt_n) begin
            state <= S_WAIT;
          end else if (rel_pend) begin
            ftk_q[V] <= 1'b0;
            state    <= S_REL;
          end else if (own_v) begin
            ftk_q <= own_tok;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end else begin
            ftk_q[V] <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (tmo_hit) begin
              tmo_q    <= 1'b1;
              state    <= S_REL;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
`endif
          end
        end
        S_WAIT: begin
          if (bt_t) begin
            ftk_q[V] <= 1'b0;
            state    <= S_REL;
          end else if (!bt_n) begin
            state <= S_FWD;
          end
        end
        S_REL: begin
          ftk_q[V] <= 1'b0;
          grant_q  <= '0;
          ptr      <= (own == IW'(NUM_REQ - 1)) ?
                      '0 : own + IW'(1);
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
